// File: rtl/preg_free_list.sv
// Physical register free list: circular buffer of free pregs feeding rename,
// refilled by commit, with a single branch checkpoint for rollback.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   i_alloc_req         rename wants one free preg this cycle
//   o_alloc_preg        preg at list head (valid when o_alloc_valid)
//   o_alloc_valid       list non-empty; grant = i_alloc_req & o_alloc_valid
//   i_commit_valid      ROB commit strobe
//   i_commit_old_preg   superseded preg returned by the committing instr
//   i_ckpt_save         branch dispatched; snapshot allocation state
//   i_branch_mispredict roll allocation state back to the snapshot
//   o_free_count        number of entries in the list
//   o_empty             o_free_count == 0

module preg_free_list #(
    parameter int PREG_WIDTH = 7,
    parameter int ARCH_REGS  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_alloc_req,
    output logic [PREG_WIDTH-1:0] o_alloc_preg,
    output logic                  o_alloc_valid,
    input  logic                  i_commit_valid,
    input  logic [PREG_WIDTH-1:0] i_commit_old_preg,
    input  logic                  i_ckpt_save,
    input  logic                  i_branch_mispredict,
    output logic [PREG_WIDTH:0]   o_free_count,
    output logic                  o_empty
);

    localparam int DEPTH = (1 << PREG_WIDTH) - ARCH_REGS;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PREG_WIDTH + 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);

    logic [PREG_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] ckpt_head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] alloc_since_ckpt;

    logic             grant;
    logic             push;
    logic [CNT_W:0]   base_cnt;
    logic [CNT_W:0]   sum_cnt;
    logic [PTR_W-1:0] head_grant;
    logic [PTR_W-1:0] head_nx;
    logic [PTR_W-1:0] tail_nx;
    logic [PTR_W-1:0] ckpt_nx;
    logic [CNT_W-1:0] count_nx;
    logic [CNT_W-1:0] since_nx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A mispredict cycle ignores rename entirely; the restored entries
    // count toward occupancy before a same-cycle push is considered.
    always_comb begin
        grant    = i_alloc_req && (count != '0) && !i_branch_mispredict;
        base_cnt = {1'b0, count};
        if (i_branch_mispredict) begin
            base_cnt = {1'b0, count} + {1'b0, alloc_since_ckpt};
        end
        push = i_commit_valid && (i_commit_old_preg != '0)
            && (base_cnt < DEPTH_W);

        head_grant = grant ? ptr_inc(head) : head;
        head_nx    = i_branch_mispredict ? ckpt_head : head_grant;
        tail_nx    = push ? ptr_inc(tail) : tail;

        sum_cnt = base_cnt + {{CNT_W{1'b0}}, push}
                - {{CNT_W{1'b0}}, grant};
        count_nx = (sum_cnt > DEPTH_W) ? CNT_W'(DEPTH) : sum_cnt[CNT_W-1:0];

        ckpt_nx  = ckpt_head;
        since_nx = alloc_since_ckpt;
        if (i_branch_mispredict) begin
            since_nx = '0;
        end else if (i_ckpt_save) begin
            // snapshot includes a grant taken in the same cycle
            ckpt_nx  = head_grant;
            since_nx = '0;
        end else if (grant) begin
            since_nx = alloc_since_ckpt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head             <= '0;
            tail             <= '0;
            ckpt_head        <= '0;
            count            <= CNT_W'(DEPTH);
            alloc_since_ckpt <= '0;
        end else begin
            head             <= head_nx;
            tail             <= tail_nx;
            ckpt_head        <= ckpt_nx;
            count            <= count_nx;
            alloc_since_ckpt <= since_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PREG_WIDTH'(ARCH_REGS + i);
            end
        end else if (push) begin
            mem[tail] <= i_commit_old_preg;
        end
    end

    assign o_alloc_preg  = mem[head];
    assign o_alloc_valid = (count != '0);
    assign o_free_count  = count;
    assign o_empty       = (count == '0);

endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list: table vectors for checkpoint
// behaviour plus queue-model sequences for drain, refill and wrap.

module tb_preg_free_list;

    logic       clk;
    logic       reset_n;
    logic       i_alloc_req;
    logic [6:0] o_alloc_preg;
    logic       o_alloc_valid;
    logic       i_commit_valid;
    logic [6:0] i_commit_old_preg;
    logic       i_ckpt_save;
    logic       i_branch_mispredict;
    logic [7:0] o_free_count;
    logic       o_empty;

    preg_free_list #(.PREG_WIDTH(7), .ARCH_REGS(32)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .i_alloc_req         (i_alloc_req),
        .o_alloc_preg        (o_alloc_preg),
        .o_alloc_valid       (o_alloc_valid),
        .i_commit_valid      (i_commit_valid),
        .i_commit_old_preg   (i_commit_old_preg),
        .i_ckpt_save         (i_ckpt_save),
        .i_branch_mispredict (i_branch_mispredict),
        .o_free_count        (o_free_count),
        .o_empty             (o_empty)
    );

    typedef struct {
        logic       a;
        logic       cv;
        logic [6:0] cp;
        logic       sv;
        logic       mi;
        logic       ev;
        logic [6:0] ep;
        logic [7:0] ec;
    } vec_t;

    typedef struct {
        logic       v;
        logic [6:0] p;
        logic [7:0] c;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   fl[$];
    int   since[$];
    int   ret[$];
    vec_t tv[14];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cmp(input string nm, input exp_t e);
        logic ok;
        checks++;
        ok = (o_alloc_valid === e.v) && (o_free_count === e.c)
          && (o_empty === (e.c == 8'd0)) && (!e.v || o_alloc_preg === e.p);
        if (!ok) begin
            errors++;
            $display("FAIL %s: got v=%0b p=%0d c=%0d e=%0b, want v=%0b p=%0d c=%0d",
                     nm, o_alloc_valid, o_alloc_preg, o_free_count, o_empty,
                     e.v, e.p, e.c);
        end
    endtask

    task automatic chk_preg(input string nm, input int want);
        checks++;
        if (o_alloc_preg !== 7'(want)) begin
            errors++;
            $display("FAIL %s: got preg=%0d, want %0d", nm, o_alloc_preg, want);
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.v = (fl.size() != 0);
        e.p = (fl.size() != 0) ? 7'(fl[0]) : 7'd0;
        e.c = 8'(fl.size());
        return e;
    endfunction

    task automatic model_reset();
        fl.delete();
        since.delete();
        for (int i = 0; i < 96; i++) fl.push_back(32 + i);
    endtask

    task automatic model_step(input logic a, cv, input logic [6:0] cp,
                              input logic sv, mi);
        int base;
        int g;
        base = fl.size() + (mi ? since.size() : 0);
        if (mi) begin
            for (int k = since.size() - 1; k >= 0; k--) fl.push_front(since[k]);
            since.delete();
        end else begin
            if (a && fl.size() != 0) begin
                g = fl.pop_front();
                if (!sv) since.push_back(g);
            end
            if (sv) since.delete();
        end
        if (cv && cp != 7'd0 && base < 96) fl.push_back(int'(cp));
    endtask

    task automatic drive(input logic a, cv, input logic [6:0] cp,
                         input logic sv, mi);
        @(negedge clk);
        i_alloc_req         = a;
        i_commit_valid      = cv;
        i_commit_old_preg   = cp;
        i_ckpt_save         = sv;
        i_branch_mispredict = mi;
        cmp("pre", model_exp());
        model_step(a, cv, cp, sv, mi);
    endtask

    task automatic finish_cycle(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got c=%0d, want an entry",
                     nm, o_free_count);
        end else begin
            e = exp_q.pop_front();
            cmp(nm, e);
        end
    endtask

    task automatic step(input string nm, input logic a, cv,
                        input logic [6:0] cp, input logic sv, mi);
        drive(a, cv, cp, sv, mi);
        exp_q.push_back(model_exp());
        finish_cycle(nm);
    endtask

    task automatic do_reset();
        exp_t r;
        @(negedge clk);
        reset_n             = 1'b0;
        i_alloc_req         = 1'b0;
        i_commit_valid      = 1'b0;
        i_commit_old_preg   = 7'd0;
        i_ckpt_save         = 1'b0;
        i_branch_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        r = '{1'b1, 7'd32, 8'd96};
        cmp("reset", r);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        exp_t r;
        reset_n             = 1'b0;
        i_alloc_req         = 1'b0;
        i_commit_valid      = 1'b0;
        i_commit_old_preg   = 7'd0;
        i_ckpt_save         = 1'b0;
        i_branch_mispredict = 1'b0;

        //        a  cv cp     sv mi   ev ep     ec
        tv[0]  = '{0, 0, 7'd0, 0, 0,  1, 7'd32, 8'd96};
        tv[1]  = '{1, 0, 7'd0, 0, 0,  1, 7'd33, 8'd95};
        tv[2]  = '{1, 0, 7'd0, 0, 0,  1, 7'd34, 8'd94};
        tv[3]  = '{0, 0, 7'd0, 1, 0,  1, 7'd34, 8'd94};
        tv[4]  = '{1, 0, 7'd0, 0, 0,  1, 7'd35, 8'd93};
        tv[5]  = '{1, 0, 7'd0, 0, 0,  1, 7'd36, 8'd92};
        tv[6]  = '{1, 0, 7'd0, 0, 0,  1, 7'd37, 8'd91};
        tv[7]  = '{0, 0, 7'd0, 0, 1,  1, 7'd34, 8'd94};
        tv[8]  = '{0, 1, 7'd0, 0, 0,  1, 7'd34, 8'd94};
        tv[9]  = '{1, 1, 7'd5, 0, 0,  1, 7'd35, 8'd94};
        tv[10] = '{1, 0, 7'd0, 1, 1,  1, 7'd34, 8'd95};
        tv[11] = '{1, 0, 7'd0, 1, 0,  1, 7'd35, 8'd94};
        tv[12] = '{1, 0, 7'd0, 0, 0,  1, 7'd36, 8'd93};
        tv[13] = '{0, 1, 7'd7, 0, 1,  1, 7'd35, 8'd95};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].a, tv[i].cv, tv[i].cp, tv[i].sv, tv[i].mi);
            exp_q.push_back('{tv[i].ev, tv[i].ep, tv[i].ec});
            finish_cycle($sformatf("vec%0d", i));
        end

        do_reset();
        repeat (3) step("idle", 0, 0, 7'd0, 0, 0);

        for (int i = 0; i < 96; i++) begin
            chk_preg("drain_order", 32 + i);
            step("drain", 1, 0, 7'd0, 0, 0);
        end
        step("alloc_empty", 1, 0, 7'd0, 0, 0);

        step("empty_push", 1, 1, 7'd40, 0, 0);
        chk_preg("empty_push_preg", 40);
        step("take40", 1, 0, 7'd0, 0, 0);

        ret.delete();
        for (int i = 0; i < 96; i++) begin
            ret.push_back(32 + ((i * 7) % 96));
            step("refill", 0, 1, 7'(ret[i]), 0, 0);
        end
        for (int i = 0; i < 96; i++) begin
            chk_preg("wrap_order", ret[i]);
            step("realloc", 1, 0, 7'd0, 0, 0);
        end

        do_reset();
        step("pre_mid", 1, 0, 7'd0, 1, 0);
        step("pre_mid", 1, 1, 7'd9, 0, 0);
        @(negedge clk);
        i_alloc_req    = 1'b1;
        i_commit_valid = 1'b1;
        i_commit_old_preg = 7'd11;
        #2;
        reset_n = 1'b0;
        #1;
        r = '{1'b1, 7'd32, 8'd96};
        cmp("mid_reset", r);
        @(posedge clk);
        #1;
        cmp("mid_reset_hold", r);
        @(negedge clk);
        i_alloc_req       = 1'b0;
        i_commit_valid    = 1'b0;
        i_commit_old_preg = 7'd0;
        reset_n           = 1'b1;
        model_reset();
        step("after_mid", 0, 0, 7'd0, 0, 0);
        step("after_mid_alloc", 1, 0, 7'd0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
